uart_alu_interface: RTL and testbench

Byte-sequencing controller between the UART receiver, the ALU and `uart_tx`. It collects three received bytes (operand A, operand B, opcode) and presents them to the combinational ALU. It then captures the ALU result and hands it to `uart_tx` with a one-cycle start pulse. It waits for `uart_tx` to report completion before accepting the next operand triple.

---
 rtl/uart_alu_interface_if.sv | 27 ++
 rtl/uart_alu_interface.sv | 74 +++++++
 tb/tb_uart_alu_interface.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_interface_if.sv
// Handshake bundle between the byte sequencer, the receiver, the ALU and uart_tx.
// The sequencer takes the slave view; whatever drives it takes the master view.
interface uart_alu_interface_if #(
  parameter int NBITS_DATA = 8,
  parameter int NBITS_OP   = 6
);
  logic                  i_rx_done;
  logic [NBITS_DATA-1:0] i_rx_data;
  logic [NBITS_DATA-1:0] i_alu_result;
  logic                  i_tx_done;
  logic [NBITS_DATA-1:0] o_data_a;
  logic [NBITS_DATA-1:0] o_data_b;
  logic [NBITS_OP-1:0]   o_op;
  logic                  o_tx_start;
  logic [NBITS_DATA-1:0] o_tx_data;
  logic                  o_busy;

  modport slave (
    input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy
  );

  modport master (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode from the UART receiver, presents them to the
// ALU, then hands the captured result to uart_tx and waits for it to finish.
module uart_alu_interface #(
  parameter int NBITS_DATA = 8,
  parameter int NBITS_OP   = 6
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  uart_alu_interface_if.slave  bus
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    SEND,
    WAIT_TX
  } state_t;

  state_t state;

  // NOTE: the data registers are reset too, so an aborted transaction leaves no stale operands.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= WAIT_A;
      bus.o_data_a   <= {NBITS_DATA{1'b0}};
      bus.o_data_b   <= {NBITS_DATA{1'b0}};
      bus.o_op       <= {NBITS_OP{1'b0}};
      bus.o_tx_data  <= {NBITS_DATA{1'b0}};
      bus.o_tx_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (state)
        WAIT_A: begin
          if (bus.i_rx_done) begin
            bus.o_data_a <= bus.i_rx_data;
            state        <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.i_rx_done) begin
            bus.o_data_b <= bus.i_rx_data;
            state        <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (bus.i_rx_done) begin
            bus.o_op <= bus.i_rx_data[NBITS_OP-1:0];
            state    <= SEND;
          end
        end
        SEND: begin
          // ALU inputs have been stable for a full cycle by this edge.
          bus.o_tx_data  <= bus.i_alu_result;
          bus.o_tx_start <= 1'b1;
          state          <= WAIT_TX;
        end
        WAIT_TX: begin
          bus.o_tx_start <= 1'b0;
          if (bus.i_tx_done) begin
            state <= WAIT_A;
          end
        end
        default: begin
          bus.o_tx_start <= 1'b0;
          state          <= WAIT_A;
        end
      endcase
    end
  end

  assign bus.o_busy = (state == SEND) || (state == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: directed vector table, hand-written corner
// sequences and randomized transactions against a bench-side ALU and transaction model.
module tb_uart_alu_interface;

  localparam int NB = 8;
  localparam int NO = 6;

  logic i_clk;
  logic i_reset_n;
  bit   clk_en;

  uart_alu_interface_if #(.NBITS_DATA(NB), .NBITS_OP(NO)) bus ();

  uart_alu_interface #(.NBITS_DATA(NB), .NBITS_OP(NO)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic prev_start = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[7];

  // Bench ALU: MIPS-style function codes, unknown codes produce 0.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign bus.i_alu_result = alu_ref(bus.o_data_a, bus.o_data_b, bus.o_op);

  initial begin
    i_clk = 1'b0;
    wait (clk_en);
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Start pulses are counted one time unit after each rising edge.
  always begin
    @(posedge i_clk);
    #1;
    if (bus.o_tx_start) begin
      start_cnt++;
      check("tx_start_single_cycle", 32'(prev_start), 32'd0);
    end
    prev_start = bus.o_tx_start;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic send_byte(input logic [7:0] d);
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = d;
    @(negedge i_clk);
    bus.i_rx_done = 1'b0;
  endtask

  // Entered on the falling edge just after the opcode edge E.
  task automatic finish_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input bit spurious, input int tx_delay, input bit both);
    logic [7:0] res;
    int base;
    res  = alu_ref(a, b, opb[5:0]);
    base = start_cnt;
    check("data_a", 32'(bus.o_data_a), 32'(a));
    check("data_b", 32'(bus.o_data_b), 32'(b));
    check("op_masked", 32'(bus.o_op), 32'(opb[5:0]));
    check("busy_in_send", 32'(bus.o_busy), 32'd1);
    check("no_start_in_send", 32'(bus.o_tx_start), 32'd0);
    @(negedge i_clk);
    check("tx_start_rise", 32'(bus.o_tx_start), 32'd1);
    check("tx_data", 32'(bus.o_tx_data), 32'(res));
    check("busy_wait_tx", 32'(bus.o_busy), 32'd1);
    @(negedge i_clk);
    check("tx_start_fall", 32'(bus.o_tx_start), 32'd0);
    if (spurious) begin
      send_byte(8'hAA);
      check("drop_busy_data_a", 32'(bus.o_data_a), 32'(a));
      check("drop_busy_state", 32'(bus.o_busy), 32'd1);
    end
    idle(tx_delay);
    check("start_count", 32'(start_cnt - base), 32'd1);
    bus.i_tx_done = 1'b1;
    if (both) begin
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = 8'h77;
    end
    @(negedge i_clk);
    bus.i_tx_done = 1'b0;
    bus.i_rx_done = 1'b0;
    check("idle_after_done", 32'(bus.o_busy), 32'd0);
    check("data_a_after_done", 32'(bus.o_data_a), 32'(a));
    check("tx_data_held", 32'(bus.o_tx_data), 32'(res));
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int gap, input bit spurious, input int tx_delay, input bit both);
    send_byte(a);
    idle(gap);
    send_byte(b);
    idle(gap);
    send_byte(opb);
    finish_txn(a, b, opb, spurious, tx_delay, both);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[7];
    logic [7:0] ra, rb, ropb;

    vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, res: 8'h08};
    vecs[1] = '{a: 8'h10, b: 8'h01, opb: 8'h22, res: 8'h0F};
    vecs[2] = '{a: 8'h05, b: 8'h03, opb: 8'hE0, res: 8'h08};
    vecs[3] = '{a: 8'hF0, b: 8'h0F, opb: 8'h24, res: 8'h00};
    vecs[4] = '{a: 8'hF0, b: 8'h0F, opb: 8'h25, res: 8'hFF};
    vecs[5] = '{a: 8'hAA, b: 8'hFF, opb: 8'h26, res: 8'h55};
    vecs[6] = '{a: 8'hFF, b: 8'h01, opb: 8'h20, res: 8'h00};
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h3F};

    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_tx_done = 1'b0;

    // Asynchronous reset with no clock running.
    i_reset_n = 1'b1;
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_data_a", 32'(bus.o_data_a), 32'd0);
    check("rst_data_b", 32'(bus.o_data_b), 32'd0);
    check("rst_op", 32'(bus.o_op), 32'd0);
    check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);

    clk_en = 1'b1;
    idle(2);
    i_reset_n = 1'b1;
    idle(1);
    check("post_rst_busy", 32'(bus.o_busy), 32'd0);

    // Stray tx_done while idle must not start anything.
    bus.i_tx_done = 1'b1;
    idle(1);
    bus.i_tx_done = 1'b0;
    idle(1);
    check("stray_tx_done_busy", 32'(bus.o_busy), 32'd0);
    check("stray_tx_done_start", 32'(start_cnt), 32'd0);

    // Directed table; first entry also drops a byte while busy.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("vec%0d_model", i), 32'(alu_ref(vecs[i].a, vecs[i].b, vecs[i].opb[5:0])),
            32'(vecs[i].res));
      run_txn(vecs[i].a, vecs[i].b, vecs[i].opb, i % 2, (i == 0), 1 + (i % 3), 1'b0);
      check($sformatf("vec%0d_result", i), 32'(bus.o_tx_data), 32'(vecs[i].res));
    end

    // tx_done and rx_done together: byte dropped, next pulse loads operand A.
    run_txn(8'h40, 8'h02, 8'h20, 0, 1'b0, 2, 1'b1);
    send_byte(8'h09);
    check("simul_next_a", 32'(bus.o_data_a), 32'h09);
    check("simul_not_busy", 32'(bus.o_busy), 32'd0);
    send_byte(8'h22);
    send_byte(8'h20);
    finish_txn(8'h09, 8'h22, 8'h20, 1'b0, 0, 1'b0);

    // Abort after two bytes.
    send_byte(8'h11);
    send_byte(8'h22);
    #2 i_reset_n = 1'b0;
    #1;
    check("abort_data_a", 32'(bus.o_data_a), 32'd0);
    check("abort_data_b", 32'(bus.o_data_b), 32'd0);
    check("abort_tx_data", 32'(bus.o_tx_data), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    idle(1);
    run_txn(8'h21, 8'h13, 8'h22, 0, 1'b0, 1, 1'b0);

    // Randomized transactions against the bench model.
    for (int i = 0; i < 25; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      ropb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 6)]};
      run_txn(ra, rb, ropb, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
